// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between the execute stage and a word-addressed
// data memory. One byte-addressed RV32I load/store is handled at a time.
// Sub-word stores are performed as read-modify-write.
//
// Handshakes: a transfer on req_* or resp_* happens on a rising clk edge
// where both valid and ready are high. The producer holds valid and its
// payload stable until that edge. req_ready is high only in IDLE, and
// resp_valid is high only in RESP.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned H/HU/W accesses complete with resp_err=1
//   undefined - the address is force-aligned and the access completes normally
module lsu_mem_ctrl #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t      state, state_next;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic [1:0]  aligned_off;
    logic        out_of_range;
    logic        illegal;
    logic        fault;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte offset with the size-natural low bits cleared. A legal aligned
    // access is unchanged, so any difference marks a misaligned request.
    always_comb begin
        aligned_off = req_addr[1:0];
        case (req_funct3)
            3'b001, 3'b101: aligned_off = {req_addr[1], 1'b0};
            3'b010:         aligned_off = 2'b00;
            default:        aligned_off = req_addr[1:0];
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (aligned_off != req_addr[1:0]);
`endif

    // Fault classification for the request presented in IDLE.
    always_comb begin
        out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
        illegal      = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) ||
                       (req_store && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101)));
`ifdef LSU_MISALIGN_TRAP_EN
        fault = misalign || out_of_range || illegal;
`else
        fault = out_of_range || illegal;
`endif
    end

    // State register. Reset returns to IDLE at once, so mem_we drops without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic and the state-decoded handshake and write-strobe outputs.
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        case (state)
            IDLE: begin
                if (req_valid) state_next = fault ? RESP : ACCESS;
            end
            ACCESS: begin
                if (!st_q) begin
                    state_next = RESP;
                end else if (f3_q == 3'b010) begin
                    mem_we     = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = MERGE;
                end
            end
            MERGE: begin
                mem_we     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane extraction with sign/zero extension for loads.
    always_comb begin
        byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Old word with the addressed byte or halfword replaced by store data.
    always_comb begin
        merged = mem_rdata;
        if (f3_q == 3'b000) merged[{off_q, 3'b000} +: 8]       = wdata_q[7:0];
        else                merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end

    // Request latch, memory address/data registers and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q       <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            wdata_q    <= 16'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        st_q       <= req_store;
                        f3_q       <= req_funct3;
                        off_q      <= aligned_off;
                        wdata_q    <= req_wdata[15:0];
                        resp_rdata <= 32'h0;
                        resp_err   <= fault;
                        // A faulting request leaves the memory address untouched.
                        if (!fault) begin
                            mem_addr <= {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
                            if (req_store) mem_wdata <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!st_q)                resp_rdata <= load_data;
                    else if (f3_q != 3'b010)  mem_wdata  <= merged;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl. It models a 1024-word data memory with
// combinational read, then checks latency, data, faults, backpressure and
// reset during a read-modify-write.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int          we_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    lsu_mem_ctrl #(.DEPTH(1024), .IDX_W(10)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Data memory model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
            we_cnt             <= we_cnt + 1;
        end
    end
    assign mem_rdata = mem[mem_addr[9:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and complete its response. lat counts clock edges from
    // the accept edge (inclusive) until resp_valid is seen.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("resp_valid_seen", {31'h0, resp_valid}, 32'h1);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          w0;
        int          k;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[6] = 32'h11223344;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_req_ready",  {31'h0, req_ready},  32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_resp_err",   {31'h0, resp_err},   32'h0);
        check("rst_mem_we",     {31'h0, mem_we},     32'h0);
        check("rst_mem_addr",   mem_addr,            32'h0);
        check("rst_mem_wdata",  mem_wdata,           32'h0);

        // SW 0x14 = DEADBEEF
        w0 = we_cnt;
        run_op(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, rd, er, lat);
        check("sw_lat",    lat, 2);
        check("sw_err",    {31'h0, er}, 32'h0);
        check("sw_rdata",  rd, 32'h0);
        check("sw_pulses", we_cnt - w0, 1);
        check("sw_mem",    mem[5], 32'hDEADBEEF);
        check("sw_addr",   mem_addr, 32'h5);

        // LW 0x14
        w0 = we_cnt;
        run_op(1'b0, 3'b010, 32'h14, 32'h0, rd, er, lat);
        check("lw_lat",    lat, 2);
        check("lw_rdata",  rd, 32'hDEADBEEF);
        check("lw_err",    {31'h0, er}, 32'h0);
        check("lw_pulses", we_cnt - w0, 0);

        // SB 0x15 = 7F
        w0 = we_cnt;
        run_op(1'b1, 3'b000, 32'h15, 32'h0000007F, rd, er, lat);
        check("sb_lat",    lat, 3);
        check("sb_err",    {31'h0, er}, 32'h0);
        check("sb_pulses", we_cnt - w0, 1);
        check("sb_mem",    mem[5], 32'hDEAD7FEF);

        // Sub-word loads
        run_op(1'b0, 3'b000, 32'h17, 32'h0, rd, er, lat);
        check("lb_rdata",  rd, 32'hFFFFFFDE);
        run_op(1'b0, 3'b100, 32'h17, 32'h0, rd, er, lat);
        check("lbu_rdata", rd, 32'h000000DE);
        run_op(1'b0, 3'b001, 32'h16, 32'h0, rd, er, lat);
        check("lh_rdata",  rd, 32'hFFFFDEAD);
        check("lh_lat",    lat, 2);

        // Misaligned LW 0x16
        w0 = we_cnt;
        run_op(1'b0, 3'b010, 32'h16, 32'h0, rd, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_mis_err",   {31'h0, er}, 32'h1);
        check("lw_mis_rdata", rd, 32'h0);
        check("lw_mis_lat",   lat, 1);
`else
        check("lw_mis_err",   {31'h0, er}, 32'h0);
        check("lw_mis_rdata", rd, 32'hDEAD7FEF);
        check("lw_mis_lat",   lat, 2);
`endif
        check("lw_mis_pulses", we_cnt - w0, 0);

        // SH 0x16 = CAFE, then LHU 0x16
        run_op(1'b1, 3'b001, 32'h16, 32'h1234CAFE, rd, er, lat);
        check("sh_lat", lat, 3);
        check("sh_mem", mem[5], 32'hCAFE7FEF);
        run_op(1'b0, 3'b101, 32'h16, 32'h0, rd, er, lat);
        check("lhu_rdata", rd, 32'h0000CAFE);

        // Out of range LW 0x1000
        run_op(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat);
        check("oor_err",   {31'h0, er}, 32'h1);
        check("oor_rdata", rd, 32'h0);
        check("oor_lat",   lat, 1);

        // Illegal store funct3=100
        w0 = we_cnt;
        run_op(1'b1, 3'b100, 32'h14, 32'h12345678, rd, er, lat);
        check("ill_st_err",    {31'h0, er}, 32'h1);
        check("ill_st_lat",    lat, 1);
        check("ill_st_pulses", we_cnt - w0, 0);
        check("ill_st_mem",    mem[5], 32'hCAFE7FEF);

        // Illegal load funct3=011
        run_op(1'b0, 3'b011, 32'h14, 32'h0, rd, er, lat);
        check("ill_ld_err", {31'h0, er}, 32'h1);

        // Backpressure: LW 0x14 held 4 cycles while a second request waits
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14;
        @(posedge clk);
        #1;
        req_funct3 = 3'b100;
        check("bp_ready_access", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("bp_valid", {31'h0, resp_valid}, 32'h1);
        check("bp_rdata", resp_rdata, 32'hCAFE7FEF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'h0, resp_valid}, 32'h1);
            check("bp_hold_rdata", resp_rdata, 32'hCAFE7FEF);
            check("bp_hold_ready", {31'h0, req_ready}, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("bp_no_accept_at_hs", {31'h0, req_ready}, 32'h1);
        check("bp_valid_dropped",   {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp_accepted", {31'h0, req_ready}, 32'h0);
        k = 0;
        while (!resp_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("bp2_valid", {31'h0, resp_valid}, 32'h1);
        check("bp2_rdata", resp_rdata, 32'h000000EF);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;

        // Reset during MERGE of SB 0x18
        w0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h18; req_wdata = 32'h000000AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mrg_we",    {31'h0, mem_we}, 32'h1);
        check("mrg_wdata", mem_wdata, 32'h112233AA);
        reset_n = 1'b0;
        #1;
        check("mrg_rst_we",    {31'h0, mem_we},    32'h0);
        check("mrg_rst_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("mrg_rst_mem",    mem[6], 32'h11223344);
        check("mrg_rst_pulses", we_cnt - w0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mrg_post_ready", {31'h0, req_ready},  32'h1);
        check("mrg_post_valid", {31'h0, resp_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
